rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Write-port scheduler and load scoreboard for the 32x32 register file. It shares the file's single write port between the ALU writeback and the load/store unit (LSU) writeback using round-robin arbitration with valid/ready handshakes. It also tracks registers with outstanding loads and stalls issue on RAW and WAW hazards against them. It sits between the execute/memory stages and the register file's RegWrite/rd/writeData inputs.

## Interface
- XLEN, 32, data width
- NREG, 32, register count; address width is clog2(NREG)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; one clock, no other clock domains
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_ready  out  1  ALU request accepted this cycle
- alu_wb_rd  in  5  ALU destination
- alu_wb_data  in  XLEN  ALU result
- lsu_wb_valid  in  1  load-data writeback request
- lsu_wb_ready  out  1  LSU request accepted this cycle
- lsu_wb_rd  in  5  load destination
- lsu_wb_data  in  XLEN  load data
- rf_we  out  1  to register file RegWrite
- rf_rd  out  5  to register file rd
- rf_wdata  out  XLEN  to register file writeData
- iss_valid  in  1  decode presents an instruction
- iss_rs1, iss_rs2  in  5 each  source registers
- iss_rd  in  5  destination register
- iss_is_load  in  1  instruction is a load
- iss_stall  out  1  hold the instruction in decode
- sb_err  out  1  sticky protocol-error flag (only with the scoreboard feature)

## Operation
- Handshake: a request fires when valid && ready. Once valid is high, rd and data stay stable until it fires.
- Arbitration: ready is combinational.
  - Only one valid: that requester gets ready.
  - Both valid: grant the requester not granted last. last_grant updates only on a fire.
- Write stage: each fire registers rf_we=(rd!=0), rf_rd=rd, rf_wdata=data.
  - A fire with rd==0 is accepted and consumed, but rf_we stays 0.
  - No cycle fires: rf_we=0; rf_rd and rf_wdata hold their values.
- Scoreboard: NREG busy bits.
  - Set: busy[iss_rd] sets when iss_valid && !iss_stall && iss_is_load && iss_rd!=0.
  - Clear: busy[lsu_wb_rd] clears on an LSU fire.
- Stall: iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]). It uses only registered busy bits; a clear in the same cycle does not unstall. busy[0] is always 0.
- Same-register set and clear in one cycle: set wins. This cannot occur legally, because a set requires busy=0 and a clear requires busy=1.
- ALU writes never touch busy bits.

## Timing
- Reset values:
  - rf_we=0, rf_rd=0, rf_wdata=0
  - all busy=0, iss_stall=0, sb_err=0
  - last_grant=ALU, so the LSU wins the first tie
  - alu_wb_ready=lsu_wb_ready=0 while rst is high
- Latency:
  - Fire in cycle N gives rf_we in cycle N+1; the file commits the write at the edge ending N+1.
  - Busy set or clear is visible to iss_stall in the cycle after the event.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate and neither waits more than 1 cycle.
- Reset mid-operation: in-flight writes, the registered write stage and all busy bits are dropped. Requesters re-present after reset.

## Configuration
- RF_SCOREBOARD_EN defined: busy bits, iss_stall and sb_err are implemented.
  - sb_err sets when an LSU fire targets a non-zero rd whose busy bit is 0.
  - sb_err clears only on rst.
- RF_SCOREBOARD_EN undefined:
  - no busy storage
  - iss_stall and sb_err tied 0
  - issue inputs ignored
  - arbiter and write stage unchanged

## Structure
- Package rf_ctrl_pkg holds:
  - XLEN, NREG and REG_AW constants
  - the requester enum (REQ_ALU, REQ_LSU) used for last_grant
- One sub-module, rf_scoreboard: busy bits, stall compare and sb_err. It is instantiated only under RF_SCOREBOARD_EN.

## Test plan
- Reset, then ALU valid alone, rd=5, data=0xDEADBEEF: ready the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- Both valid for 4 cycles right after reset: grants go LSU, ALU, LSU, ALU; rf_we stays high all 4 cycles.
- ALU fire with rd=0: ready=1; next cycle rf_we=0.
- Issue load, rd=7; next cycle issue add reading rs1=7: iss_stall=1 until the cycle after an LSU fire to x7, then 0. Also check a WAW issue with rd=7 stalls the same way.
- LSU fire to rd=9 with busy[9]=0: sb_err=1 from the next cycle and stays 1 until rst.
- Both valid with rst asserted mid-burst: both readies 0; next cycle rf_we=0; after reset, busy is all 0 and a load-dependent issue is not stalled.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared constants and requester type for the register-file write scheduler
package rf_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    // Identifies which writeback source owned the write port most recently
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - outstanding-load busy bits, issue hazard stall and sticky LSU protocol error
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_is_load,
    input  logic              lsu_fire,
    input  logic [REG_AW-1:0] lsu_rd,
    output logic              iss_stall,
    output logic              sb_err
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            load_issue;

    // Stall looks only at registered busy bits, so a same-cycle clear does not release it
    assign iss_stall  = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]);
    assign load_issue = iss_valid && !iss_stall && iss_is_load && (iss_rd != '0);

    // Apply the LSU clear first so a same-register set overrides it; x0 is never busy
    always_comb begin
        busy_next = busy;
        if (lsu_fire) begin
            busy_next[lsu_rd] = 1'b0;
        end
        if (load_issue) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy-bit storage
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Sticky flag for load data arriving at a register with no outstanding load
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (lsu_fire && (lsu_rd != '0) && !busy[lsu_rd]) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - round-robin ALU/LSU write-port scheduler; RF_SCOREBOARD_EN adds the load scoreboard
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [REG_AW-1:0] alu_wb_rd,
    input  logic [XLEN-1:0]   alu_wb_data,
    input  logic              lsu_wb_valid,
    output logic              lsu_wb_ready,
    input  logic [REG_AW-1:0] lsu_wb_rd,
    input  logic [XLEN-1:0]   lsu_wb_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_is_load,
    output logic              iss_stall,
    output logic              sb_err
);

    req_e last_grant;
    logic alu_fire;
    logic lsu_fire;

    // On a tie the requester that did not win last time gets the port; nothing is granted in reset
    assign alu_wb_ready = !rst && alu_wb_valid && (!lsu_wb_valid || (last_grant == REQ_LSU));
    assign lsu_wb_ready = !rst && lsu_wb_valid && (!alu_wb_valid || (last_grant == REQ_ALU));
    assign alu_fire     = alu_wb_valid && alu_wb_ready;
    assign lsu_fire     = lsu_wb_valid && lsu_wb_ready;

    // Round-robin history advances only when a request actually fires
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_ALU;
        end else if (lsu_fire) begin
            last_grant <= REQ_LSU;
        end else if (alu_fire) begin
            last_grant <= REQ_ALU;
        end
    end

    // Registered write stage; writes to x0 are consumed without asserting the write enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (alu_fire) begin
            rf_we    <= (alu_wb_rd != '0);
            rf_rd    <= alu_wb_rd;
            rf_wdata <= alu_wb_data;
        end else if (lsu_fire) begin
            rf_we    <= (lsu_wb_rd != '0);
            rf_rd    <= lsu_wb_rd;
            rf_wdata <= lsu_wb_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rd      (iss_rd),
        .iss_is_load (iss_is_load),
        .lsu_fire    (lsu_fire),
        .lsu_rd      (lsu_wb_rd),
        .iss_stall   (iss_stall),
        .sb_err      (sb_err)
    );
`else
    // Without the scoreboard the issue interface is ignored and never stalls
    logic unused_iss;
    assign unused_iss = &{1'b0, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_is_load};
    assign iss_stall  = 1'b0;
    assign sb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;
    import rf_ctrl_pkg::*;

`ifdef RF_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_wb_valid, lsu_wb_valid;
    logic              alu_wb_ready, lsu_wb_ready;
    logic [REG_AW-1:0] alu_wb_rd, lsu_wb_rd;
    logic [XLEN-1:0]   alu_wb_data, lsu_wb_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              iss_valid, iss_is_load;
    logic [REG_AW-1:0] iss_rs1, iss_rs2, iss_rd;
    logic              iss_stall, sb_err;

    int checks = 0;
    int errors = 0;

    rf_wb_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_ready (lsu_wb_ready),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rd       (iss_rd),
        .iss_is_load  (iss_is_load),
        .iss_stall    (iss_stall),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iss(input logic v, input logic ld, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        iss_valid   = v;
        iss_is_load = ld;
        iss_rs1     = rs1;
        iss_rs2     = rs2;
        iss_rd      = rd;
    endtask

    initial begin
        rst = 1'b1;
        alu_wb_valid = 0; lsu_wb_valid = 0;
        alu_wb_rd = 0; lsu_wb_rd = 0; alu_wb_data = 0; lsu_wb_data = 0;
        set_iss(0, 0, 0, 0, 0);
        tick();
        alu_wb_valid = 1; lsu_wb_valid = 1; alu_wb_rd = 3; lsu_wb_rd = 4;
        #1;
        check("rst_alu_ready", alu_wb_ready, 0);
        check("rst_lsu_ready", lsu_wb_ready, 0);
        tick();
        rst = 0; alu_wb_valid = 0; lsu_wb_valid = 0;
        check("reset_we", rf_we, 0);
        check("reset_rd", rf_rd, 0);
        check("reset_wdata", rf_wdata, 0);
        check("reset_stall", iss_stall, 0);
        check("reset_sb_err", sb_err, 0);

        // ALU alone, rd=5
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF;
        #1;
        check("alu_alone_ready", alu_wb_ready, 1);
        check("alu_alone_lsu_ready", lsu_wb_ready, 0);
        tick();
        alu_wb_valid = 0;
        check("alu_wr_we", rf_we, 1);
        check("alu_wr_rd", rf_rd, 5);
        check("alu_wr_data", rf_wdata, 32'hDEADBEEF);

        // ALU to x0: consumed, no write
        alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h12345678;
        #1;
        check("x0_ready", alu_wb_ready, 1);
        tick();
        alu_wb_valid = 0;
        check("x0_we", rf_we, 0);
        tick();
        check("idle_we", rf_we, 0);
        check("idle_rd_hold", rf_rd, 0);
        check("idle_wdata_hold", rf_wdata, 32'h12345678);

        // RAW hazard on a load to x7
        set_iss(1, 1, 1, 2, 7);
        #1;
        check("load7_issue_stall", iss_stall, 0);
        tick();
        set_iss(1, 0, 7, 3, 8);
        #1;
        check("raw_stall_a", iss_stall, SB);
        tick();
        lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 32'h77;
        #1;
        check("raw_stall_b", iss_stall, SB);
        check("lsu7_ready", lsu_wb_ready, 1);
        tick();
        lsu_wb_valid = 0;
        check("lsu7_we", rf_we, 1);
        check("lsu7_rd", rf_rd, 7);
        check("lsu7_data", rf_wdata, 32'h77);
        check("raw_released", iss_stall, 0);
        check("legal_lsu_no_err", sb_err, 0);
        tick();

        // WAW hazard on x7
        set_iss(1, 1, 1, 2, 7);
        #1;
        check("waw_load_issue", iss_stall, 0);
        tick();
        set_iss(1, 0, 1, 2, 7);
        lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 32'h99;
        #1;
        check("waw_stall", iss_stall, SB);
        tick();
        lsu_wb_valid = 0;
        check("waw_released", iss_stall, 0);
        check("waw_no_err", sb_err, 0);
        set_iss(0, 0, 0, 0, 0);

        // Fresh reset so LSU wins the first tie
        rst = 1;
        tick();
        rst = 0;
        alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 32'hA0;
        lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'hB0;
        #1;
        check("rr0_lsu_ready", lsu_wb_ready, 1);
        check("rr0_alu_ready", alu_wb_ready, 0);
        tick();
        check("rr0_we", rf_we, 1);
        check("rr0_rd", rf_rd, 9);
        check("rr0_data", rf_wdata, 32'hB0);
        check("sb_err_set", sb_err, SB);
        check("rr1_alu_ready", alu_wb_ready, 1);
        check("rr1_lsu_ready", lsu_wb_ready, 0);
        tick();
        check("rr1_we", rf_we, 1);
        check("rr1_rd", rf_rd, 1);
        check("rr1_data", rf_wdata, 32'hA0);
        check("rr2_lsu_ready", lsu_wb_ready, 1);
        set_iss(1, 1, 0, 0, 12);
        tick();
        check("rr2_we", rf_we, 1);
        check("rr2_rd", rf_rd, 9);
        check("rr3_alu_ready", alu_wb_ready, 1);
        set_iss(1, 0, 12, 0, 13);
        #1;
        check("load12_stall", iss_stall, SB);
        tick();
        check("rr3_we", rf_we, 1);
        check("rr3_rd", rf_rd, 1);
        check("sb_err_sticky", sb_err, SB);

        // Reset mid-burst
        rst = 1;
        #1;
        check("midrst_alu_ready", alu_wb_ready, 0);
        check("midrst_lsu_ready", lsu_wb_ready, 0);
        tick();
        rst = 0; alu_wb_valid = 0; lsu_wb_valid = 0;
        check("midrst_we", rf_we, 0);
        check("midrst_sb_err", sb_err, 0);
        #1;
        check("midrst_no_stall", iss_stall, 0);
        set_iss(0, 0, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
